// File: rtl/motor_pkg.sv
// Shared commutation types, the six-step gate LUT and modulo-6 step arithmetic.
package motor_pkg;

  typedef logic [2:0] step_t;
  typedef logic [5:0] pattern_t;

  // {hiA,hiB,hiC,loA,loB,loC} per step 0..5
  localparam pattern_t STEP_LUT [0:5] = '{
    6'b001010, 6'b100010, 6'b100001, 6'b010001, 6'b010100, 6'b001100
  };

  localparam pattern_t BRAKE_PATTERN = 6'b000111;

  function automatic step_t step_inc(input step_t s);
    return (s >= 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic step_t step_dec(input step_t s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

endpackage

// File: rtl/dead_time_channel.sv
// One motor phase: keeps the high and low switch from conducting together and
// enforces K_DEADTIME idle cycles before the opposite switch may turn on.
module dead_time_channel #(
  parameter int K_DEADTIME = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_hi,
  input  logic i_req_lo,
  output logic o_hi,
  output logic o_lo,
  output logic o_active
);

  if (K_DEADTIME == 0) begin : g_bypass
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        o_hi <= 1'b0;
        o_lo <= 1'b0;
      end else begin
        o_hi <= i_req_hi;
        o_lo <= i_req_lo;
      end
    end
    assign o_active = 1'b0;
  end else begin : g_dt
    localparam int CW = $clog2(K_DEADTIME + 1);

    logic [CW-1:0] r_cnt;
    logic          r_hi;
    logic          r_lo;
    logic          r_last_off_hi;
    logic          r_rechop_ok;

    logic [CW-1:0] w_cnt_d;
    logic          w_hi_d;
    logic          w_lo_d;
    logic          w_hi_fall;
    logic          w_lo_fall;
    logic          w_window_done;
    logic          w_last_off_hi_d;
    logic          w_rechop_ok_d;

    // A count of 1 means this edge completes the K_DEADTIME idle cycles.
    assign w_window_done = (r_cnt <= CW'(1));

    // Same-side re-chop bypasses the window only while the opposite switch
    // has not been requested since the fall.
    always_comb begin
      w_hi_d          = i_req_hi & ~i_req_lo & ~r_lo &
                        (w_window_done | (r_last_off_hi & r_rechop_ok));
      w_lo_d          = i_req_lo & ~i_req_hi & ~r_hi &
                        (w_window_done | (~r_last_off_hi & r_rechop_ok));
      w_hi_fall       = r_hi & ~w_hi_d;
      w_lo_fall       = r_lo & ~w_lo_d;
      w_cnt_d         = r_cnt;
      w_last_off_hi_d = r_last_off_hi;
      w_rechop_ok_d   = r_rechop_ok;
      if (w_hi_fall) begin
        w_cnt_d         = CW'(K_DEADTIME);
        w_last_off_hi_d = 1'b1;
        w_rechop_ok_d   = ~i_req_lo;
      end else if (w_lo_fall) begin
        w_cnt_d         = CW'(K_DEADTIME);
        w_last_off_hi_d = 1'b0;
        w_rechop_ok_d   = ~i_req_hi;
      end else if (w_hi_d | w_lo_d) begin
        w_cnt_d = '0;
      end else if (r_cnt != '0) begin
        w_cnt_d = r_cnt - CW'(1);
        if (r_last_off_hi ? i_req_lo : i_req_hi) w_rechop_ok_d = 1'b0;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt         <= '0;
        r_hi          <= 1'b0;
        r_lo          <= 1'b0;
        r_last_off_hi <= 1'b0;
        r_rechop_ok   <= 1'b0;
      end else begin
        r_cnt         <= w_cnt_d;
        r_hi          <= w_hi_d;
        r_lo          <= w_lo_d;
        r_last_off_hi <= w_last_off_hi_d;
        r_rechop_ok   <= w_rechop_ok_d;
      end
    end

    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
    assign o_active = (r_cnt != '0);
  end

endmodule

// File: rtl/pattern_generator_dt.sv
// Six-step commutation: zig-zag substep tracking, PWM duty gating, brake and
// per-phase dead-time insertion on the gate pattern.
module pattern_generator_dt
  import motor_pkg::*;
#(
  parameter int K_NSUBSTEPS = 10,
  parameter int K_DEADTIME  = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [2:0]                       i_force_step_value,
  input  logic                             i_force_step_trigger,
  input  logic [$clog2(K_NSUBSTEPS)-1:0]   i_force_substep,
  input  logic                             i_step_trigger,
  input  logic                             i_step_polarity_rev,
  input  logic                             i_step_reverse,
  input  logic                             i_brake,
  input  logic                             i_bypass_power,
  input  logic                             i_cmd_on_lsb,
  input  logic [$clog2(K_NSUBSTEPS+1)-1:0] i_power,
  output logic [5:0]                       o_pattern,
  output logic [2:0]                       o_step,
  output logic [$clog2(K_NSUBSTEPS)-1:0]   o_substep,
  output logic                             o_dt_active
);

  localparam int SW = $clog2(K_NSUBSTEPS);

  step_t    r_step;
  logic [SW-1:0] r_substep;
  pattern_t r_raw;

  logic     w_count_up;
  logic     w_at_limit;
  step_t    w_step_sel;
  logic     w_power_on;
  pattern_t w_mask;
  pattern_t w_raw_d;
  logic [2:0] w_hi;
  logic [2:0] w_lo;
  logic [2:0] w_active;

  // Odd steps count the substep the other way, so the PWM ramp zig-zags.
  assign w_count_up = ~(r_step[0] ^ i_step_polarity_rev);
  assign w_at_limit = w_count_up ? (r_substep == SW'(K_NSUBSTEPS - 1))
                                 : (r_substep == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step    <= 3'd5;
      r_substep <= '0;
    end else if (i_force_step_trigger) begin
      r_step    <= (i_force_step_value < 3'd6) ? i_force_step_value : 3'd0;
      r_substep <= i_force_substep;
    end else if (i_step_trigger) begin
      if (w_at_limit)
        r_step <= i_step_polarity_rev ? step_dec(r_step) : step_inc(r_step);
      else if (w_count_up)
        r_substep <= r_substep + SW'(1);
      else
        r_substep <= r_substep - SW'(1);
    end
  end

  assign w_step_sel = i_step_reverse ? step_dec(r_step) : step_inc(r_step);
  assign w_power_on = i_bypass_power |
                      ((int'(i_power) > int'(r_substep)) ^ i_cmd_on_lsb);
  assign w_mask     = {{3{w_power_on | i_cmd_on_lsb}}, {3{w_power_on | ~i_cmd_on_lsb}}};

  always_comb begin
    w_raw_d = STEP_LUT[w_step_sel] & w_mask;
    if (i_brake) w_raw_d = BRAKE_PATTERN;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_raw <= '0;
    else       r_raw <= w_raw_d;
  end

  // Phase p: high switch at raw bit 5-p, low switch at raw bit 2-p.
  for (genvar p = 0; p < 3; p++) begin : g_phase
    dead_time_channel #(.K_DEADTIME(K_DEADTIME)) u_dt (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_req_hi (r_raw[5-p]),
      .i_req_lo (r_raw[2-p]),
      .o_hi     (w_hi[p]),
      .o_lo     (w_lo[p]),
      .o_active (w_active[p])
    );
  end

  assign o_pattern   = {w_hi[0], w_hi[1], w_hi[2], w_lo[0], w_lo[1], w_lo[2]};
  assign o_step      = r_step;
  assign o_substep   = r_substep;
  assign o_dt_active = |w_active;

endmodule

// File: tb/tb_pattern_generator_dt.sv
// Scoreboard bench for pattern_generator_dt: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_pattern_generator_dt;

  localparam int K_NSUBSTEPS = 10;
  localparam int K_DEADTIME  = 4;
  localparam int KP = 0, KS = 1, KU = 2, KD = 3;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [2:0] i_force_step_value;
  logic       i_force_step_trigger;
  logic [3:0] i_force_substep;
  logic       i_step_trigger;
  logic       i_step_polarity_rev;
  logic       i_step_reverse;
  logic       i_brake;
  logic       i_bypass_power;
  logic       i_cmd_on_lsb;
  logic [3:0] i_power;
  logic [5:0] o_pattern;
  logic [2:0] o_step;
  logic [3:0] o_substep;
  logic       o_dt_active;

  pattern_generator_dt #(.K_NSUBSTEPS(K_NSUBSTEPS), .K_DEADTIME(K_DEADTIME)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_force_step_value(i_force_step_value), .i_force_step_trigger(i_force_step_trigger),
    .i_force_substep(i_force_substep), .i_step_trigger(i_step_trigger),
    .i_step_polarity_rev(i_step_polarity_rev), .i_step_reverse(i_step_reverse),
    .i_brake(i_brake), .i_bypass_power(i_bypass_power), .i_cmd_on_lsb(i_cmd_on_lsb),
    .i_power(i_power), .o_pattern(o_pattern), .o_step(o_step),
    .o_substep(o_substep), .o_dt_active(o_dt_active)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    int         kind;
    logic [5:0] val;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_overlap = 1'b0;

  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [5:0] actual(input int kind);
    case (kind)
      KP:      return o_pattern;
      KS:      return {3'b000, o_step};
      KU:      return {2'b00, o_substep};
      default: return {5'b00000, o_dt_active};
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      KP:      return "pattern";
      KS:      return "step";
      KU:      return "substep";
      default: return "dt_active";
    endcase
  endfunction

  always @(negedge i_clk) begin : monitor
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc < edge_cnt) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s cyc %0d: expectation never reached the monitor", kname(q[i].kind), q[i].cyc);
        q.delete(i);
      end else if (q[i].cyc == edge_cnt) begin
        n_vec++;
        if (actual(q[i].kind) !== q[i].val) begin
          n_bad++;
          $display("FAIL %s cyc %0d: got %b expected %b", kname(q[i].kind), edge_cnt,
                   actual(q[i].kind), q[i].val);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
    if (chk_overlap) begin
      n_vec++;
      if ((o_pattern[5:3] & o_pattern[2:0]) != 3'b000) begin
        n_bad++;
        $display("FAIL overlap cyc %0d: got pattern %b expected no phase hi&lo", edge_cnt, o_pattern);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_at(input int cyc, input int kind, input logic [5:0] val);
    q.push_back('{cyc: cyc, kind: kind, val: val});
  endtask

  task automatic expect_reset_now();
    expect_at(edge_cnt, KP, 6'b000000);
    expect_at(edge_cnt, KS, 6'd5);
    expect_at(edge_cnt, KU, 6'd0);
    expect_at(edge_cnt, KD, 6'd0);
  endtask

  task automatic force_step(input logic [2:0] v, input logic [3:0] s);
    i_force_step_value   = v;
    i_force_substep      = s;
    i_force_step_trigger = 1'b1;
    tick();
    i_force_step_trigger = 1'b0;
  endtask

  initial begin : stim
    int n;
    i_rst = 1'b1;
    i_force_step_value = 3'd0; i_force_step_trigger = 1'b0; i_force_substep = 4'd0;
    i_step_trigger = 1'b0; i_step_polarity_rev = 1'b0; i_step_reverse = 1'b0;
    i_brake = 1'b0; i_bypass_power = 1'b0; i_cmd_on_lsb = 1'b0; i_power = 4'd10;

    // Power-up reset, then first turn-on of step 5's pattern without delay.
    tick();
    expect_reset_now();
    tick(); tick();
    i_rst = 1'b0;
    n = edge_cnt + 1;
    expect_at(n, KS, 6'd5);
    expect_at(n, KU, 6'd0);
    expect_at(n + 1, KP, 6'b001010);
    expect_at(n + 1, KD, 6'd0);
    repeat (4) tick();

    // Force step 1: phase C swaps hi->lo through a dead-time window.
    n = edge_cnt + 1;
    expect_at(n, KS, 6'd1);
    expect_at(n + 2, KP, 6'b100000);
    expect_at(n + 2, KD, 6'd1);
    expect_at(n + 5, KD, 6'd1);
    expect_at(n + 6, KP, 6'b100001);
    expect_at(n + 6, KD, 6'd0);
    force_step(3'd1, 4'd0);
    repeat (8) tick();

    // Force step 2: clean commutation to 010001 two edges later.
    n = edge_cnt + 1;
    expect_at(n, KS, 6'd2);
    expect_at(n, KU, 6'd0);
    expect_at(n + 2, KP, 6'b010001);
    force_step(3'd2, 4'd0);
    repeat (8) tick();

    // Out-of-range force value, then zig-zag wrap at the top substep.
    n = edge_cnt + 1;
    expect_at(n, KS, 6'd0);
    expect_at(n, KU, 6'd9);
    force_step(3'd7, 4'd9);
    i_step_trigger = 1'b1;
    n = edge_cnt + 1;
    expect_at(n, KS, 6'd1);
    expect_at(n, KU, 6'd9);
    expect_at(n + 1, KS, 6'd1);
    expect_at(n + 1, KU, 6'd8);
    tick(); tick();
    i_step_trigger = 1'b0;
    repeat (8) tick();

    // PWM on high side, power 3: hiB on for substeps 0..2, loC steady.
    i_power = 4'd3;
    n = edge_cnt + 1;
    for (int k = 0; k < 10; k++)
      expect_at(n + 2 + k, KP, (k < 3) ? 6'b010001 : 6'b000001);
    force_step(3'd2, 4'd0);
    i_step_trigger = 1'b1;
    repeat (9) tick();
    i_step_trigger = 1'b0;
    tick();

    // PWM on low side: loC chopped and re-enabled inside its own window.
    i_cmd_on_lsb = 1'b1;
    n = edge_cnt + 1;
    expect_at(n + 1, KP, 6'b010001);
    expect_at(n + 2, KD, 6'd1);
    for (int k = 0; k < 10; k++)
      expect_at(n + 2 + k, KP, (k < 3) ? 6'b010000 : 6'b010001);
    force_step(3'd2, 4'd0);
    i_step_trigger = 1'b1;
    repeat (9) tick();
    i_step_trigger = 1'b0;
    tick();

    // High-side re-chop: hiB drops for one cycle and returns immediately.
    i_cmd_on_lsb = 1'b0;
    n = edge_cnt + 1;
    expect_at(n + 1, KP, 6'b000001);
    expect_at(n + 1, KD, 6'd1);
    expect_at(n + 2, KP, 6'b010001);
    force_step(3'd2, 4'd0);
    repeat (8) tick();

    // Held brake: loA at once, loB after the hiB dead time.
    n = edge_cnt + 1;
    for (int k = 1; k < 5; k++) begin
      expect_at(n + k, KP, 6'b000101);
      expect_at(n + k, KD, 6'd1);
    end
    expect_at(n + 5, KP, 6'b000111);
    expect_at(n + 5, KD, 6'd0);
    i_brake = 1'b1;
    repeat (6) tick();
    i_brake = 1'b0;
    repeat (8) tick();

    // Brake released mid-window: hiB waits out the full window, loB never on.
    n = edge_cnt + 1;
    chk_overlap = 1'b1;
    expect_at(n + 1, KP, 6'b000101);
    expect_at(n + 2, KP, 6'b000101);
    expect_at(n + 3, KP, 6'b000001);
    expect_at(n + 4, KP, 6'b000001);
    expect_at(n + 4, KD, 6'd1);
    expect_at(n + 5, KP, 6'b010001);
    i_brake = 1'b1;
    tick(); tick();
    i_brake = 1'b0;
    repeat (6) tick();
    chk_overlap = 1'b0;

    // Reset asserted inside a dead-time window, then undelayed restart.
    i_brake = 1'b1;
    repeat (3) tick();
    #2;
    i_rst = 1'b1;
    i_brake = 1'b0;
    expect_reset_now();
    tick();
    expect_reset_now();
    tick();
    i_rst = 1'b0;
    n = edge_cnt + 1;
    expect_at(n + 1, KP, 6'b001010);
    expect_at(n + 1, KD, 6'd0);
    repeat (4) tick();

    repeat (2) tick();
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL pending: got %0d unchecked expectations expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
